shiftadd_mul_seq: RTL and testbench

Sequential 10x10-bit multiplier controller for the ECC datapath. It multiplies an unsigned multiplicand by an unsigned multiplier using a two-shifter add step. Each cycle it schedules the two lowest remaining set bits of the multiplier as shift amounts and accumulates the shifted multiplicand into an internal 20-bit accumulator. Latency therefore depends on the multiplier's popcount, not its width, which makes it the scheduler that sits in front of the shift-add datapath in the ECC arithmetic path.

---
 rtl/shiftadd_mul_seq_if.sv | 32 +++
 rtl/shiftadd_mul_seq.sv | 138 +++++++++++++
 tb/tb_shiftadd_mul_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/shiftadd_mul_seq_if.sv
// Request/response bundle for the shift-add multiplier scheduler.
//   master : drives start_i, abort_i, a_i, b_i; observes status, product and shift schedule
//   slave  : the multiplier itself
interface shiftadd_mul_seq_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned BW = 10,
  parameter int unsigned SW = 4
) ();

  logic              start_i;
  logic              abort_i;
  logic [AW-1:0]     a_i;
  logic [BW-1:0]     b_i;
  logic              busy_o;
  logic              done_o;
  logic [AW+BW-1:0]  prod_o;
  logic [SW-1:0]     shift1_o;
  logic              shift1_v_o;
  logic [SW-1:0]     shift2_o;
  logic              shift2_v_o;

  modport master (
    output start_i, abort_i, a_i, b_i,
    input  busy_o, done_o, prod_o, shift1_o, shift1_v_o, shift2_o, shift2_v_o
  );

  modport slave (
    input  start_i, abort_i, a_i, b_i,
    output busy_o, done_o, prod_o, shift1_o, shift1_v_o, shift2_o, shift2_v_o
  );

endinterface

// File: rtl/shiftadd_mul_seq.sv
// Sequential unsigned AWxBW multiplier scheduler. Each RUN cycle retires the two
// lowest set bits of the remaining multiplier, adding the correspondingly shifted
// multiplicand into a (AW+BW)-bit accumulator, so latency tracks popcount(b).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      slave side of shiftadd_mul_seq_if (start/abort/operands in,
//            busy/done/product and the live shift schedule out)
module shiftadd_mul_seq #(
  parameter int unsigned AW = 10,
  parameter int unsigned BW = 10,
  parameter int unsigned SW = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  shiftadd_mul_seq_if.slave      bus
);

  localparam int unsigned PW = AW + BW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [BW-1:0]   r_q, r_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Schedule lookahead derived from the remaining multiplier bits.
  logic [SW-1:0]   s1_c, s2_c;
  logic            v1_c, v2_c;
  logic [BW-1:0]   m1_c, m2_c;
  logic [BW-1:0]   r_rest_c;
  logic [BW-1:0]   r_next_c;
  logic [PW-1:0]   t1_c, t2_c;
  logic [PW-1:0]   acc_sum_c;

  // Index of the lowest set bit; 0 when the vector is empty (caller gates with valid).
  function automatic logic [SW-1:0] low_idx(input logic [BW-1:0] v);
    logic [SW-1:0] idx;
    idx = '0;
    for (int i = int'(BW) - 1; i >= 0; i--) begin
      if (v[i]) idx = SW'(i);
    end
    return idx;
  endfunction

  // Pick the two lowest set bits, form the shifted addends and the cleared multiplier.
  always_comb begin
    s1_c      = low_idx(r_q);
    v1_c      = |r_q;
    m1_c      = v1_c ? (BW'(1) << s1_c) : '0;
    r_rest_c  = r_q & ~m1_c;
    s2_c      = low_idx(r_rest_c);
    v2_c      = |r_rest_c;
    m2_c      = v2_c ? (BW'(1) << s2_c) : '0;
    r_next_c  = r_rest_c & ~m2_c;
    t1_c      = v1_c ? (PW'(a_q) << s1_c) : '0;
    t2_c      = v2_c ? (PW'(a_q) << s2_c) : '0;
    acc_sum_c = acc_q + t1_c + t2_c;
  end

  // Next-state and datapath update; abort wins over completion in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    r_d     = r_q;
    acc_d   = acc_q;
    prod_d  = prod_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          a_d     = bus.a_i;
          r_d     = bus.b_i;
          acc_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else begin
          r_d   = r_next_c;
          acc_d = acc_sum_c;
          if (r_next_c == '0) begin
            prod_d  = acc_sum_c;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.prod_o = prod_q;

  // Observe ports: live schedule while running, quiet otherwise (R may hold stale bits after abort).
  assign bus.shift1_o   = (state_q == RUN) ? s1_c : '0;
  assign bus.shift1_v_o = (state_q == RUN) && v1_c;
  assign bus.shift2_o   = (state_q == RUN) ? s2_c : '0;
  assign bus.shift2_v_o = (state_q == RUN) && v2_c;

endmodule

// File: tb/tb_shiftadd_mul_seq.sv
// Bench for shiftadd_mul_seq: directed literal cases plus a randomized run, all
// checked every cycle against a popcount/queue-level model of the multiplier.
module tb_shiftadd_mul_seq;

  logic clk;
  logic reset_n;

  shiftadd_mul_seq_if #(.AW(10), .BW(10), .SW(4)) bus ();

  shiftadd_mul_seq #(.AW(10), .BW(10), .SW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 run, 2 done; m_bits holds the not-yet-retired set-bit indices of b.
  int         m_mode = 0;
  int         m_bits[$];
  logic [19:0] m_prod = '0;
  logic [19:0] m_pend = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0;
      m_prod = '0;
      m_pend = '0;
      m_bits.delete();
    end else begin
      case (m_mode)
        0, 2: begin
          if (bus.start_i) begin
            m_bits.delete();
            for (int i = 0; i < 10; i++) if (bus.b_i[i]) m_bits.push_back(i);
            m_pend = 20'(bus.a_i) * 20'(bus.b_i);
            m_mode = 1;
          end else begin
            m_mode = 0;
          end
        end
        default: begin
          if (bus.abort_i) begin
            m_mode = 0;
          end else begin
            repeat (2) if (m_bits.size() > 0) void'(m_bits.pop_front());
            if (m_bits.size() == 0) begin
              m_prod = m_pend;
              m_mode = 2;
            end
          end
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic       run;
    int         n;
    run = (m_mode == 1);
    n   = m_bits.size();
    check("busy",  32'(bus.busy_o), 32'(run));
    check("done",  32'(bus.done_o), 32'(m_mode == 2));
    check("prod",  32'(bus.prod_o), 32'(m_prod));
    check("s1_v",  32'(bus.shift1_v_o), 32'(run && n >= 1));
    check("s1",    32'(bus.shift1_o), (run && n >= 1) ? 32'(m_bits[0]) : 32'd0);
    check("s2_v",  32'(bus.shift2_v_o), 32'(run && n >= 2));
    check("s2",    32'(bus.shift2_o), (run && n >= 2) ? 32'(m_bits[1]) : 32'd0);
  end

  logic [3:0] c1_s1, c1_s2;
  logic       c1_v1, c1_v2;

  // Launch at the current low phase, wait (bounded) for done, check literal latency/busy/product.
  task automatic do_mul(input logic [9:0] a, input logic [9:0] b,
                        input logic [19:0] exp_p, input int exp_lat);
    int lat   = 0;
    int nbusy = 0;
    bit got   = 0;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.start_i = 1'b1;
    while (!got && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        bus.start_i = 1'b0;
        c1_s1 = bus.shift1_o;
        c1_v1 = bus.shift1_v_o;
        c1_s2 = bus.shift2_o;
        c1_v2 = bus.shift2_v_o;
      end
      if (bus.busy_o) nbusy++;
      if (bus.done_o) got = 1;
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency",   32'(lat), 32'(exp_lat));
    check("busy_cnt",  32'(nbusy), 32'(exp_lat - 1));
    check("prod_lit",  32'(bus.prod_o), 32'(exp_p));
  endtask

  function automatic logic [9:0] pick_b();
    case ($urandom_range(0, 3))
      0:       return 10'd0;
      1:       return 10'h3FF;
      2:       return 10'(1 << $urandom_range(0, 9));
      default: return 10'($urandom);
    endcase
  endfunction

  initial begin
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    reset_n     = 1'b1;
    #1 reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_prod", 32'(bus.prod_o), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    #1;

    do_mul(10'd3, 10'd5, 20'd15, 2);
    check("c3x5_s1", 32'(c1_s1), 32'd0);
    check("c3x5_s2", 32'(c1_s2), 32'd2);
    check("c3x5_v",  32'({c1_v1, c1_v2}), 32'd3);
    @(negedge clk); #1;

    do_mul(10'd77, 10'd0, 20'd0, 2);
    check("b0_v", 32'({c1_v1, c1_v2}), 32'd0);
    @(negedge clk); #1;

    do_mul(10'd1023, 10'd1023, 20'd1046529, 6);
    @(negedge clk); #1;

    do_mul(10'd7, 10'h200, 20'd3584, 2);
    check("b200_s1", 32'(c1_s1), 32'd9);
    check("b200_v",  32'({c1_v1, c1_v2}), 32'd2);
    // Back-to-back from the DONE cycle: same latency means no idle bubble.
    do_mul(10'd2, 10'd3, 20'd6, 2);
    @(negedge clk); #1;

    // Abort in the second RUN cycle: product stays 6, no done pulse.
    bus.a_i = 10'd5; bus.b_i = 10'h3FF; bus.start_i = 1'b1;
    @(negedge clk); #1; bus.start_i = 1'b0;
    @(negedge clk); #1; bus.abort_i = 1'b1;
    @(negedge clk); #1; bus.abort_i = 1'b0;
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    check("abort_done", 32'(bus.done_o), 32'd0);
    check("abort_prod", 32'(bus.prod_o), 32'd6);
    repeat (4) @(negedge clk);
    #1;

    // Asynchronous reset mid-RUN clears everything at once.
    bus.start_i = 1'b1;
    @(negedge clk); #1; bus.start_i = 1'b0;
    @(negedge clk); #2; reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy_o), 32'd0);
    check("arst_prod", 32'(bus.prod_o), 32'd0);
    check("arst_s1v",  32'(bus.shift1_v_o), 32'd0);
    @(negedge clk); #1; reset_n = 1'b1;
    @(negedge clk); #1;

    // Randomized traffic: starts, aborts and operands all checked by the model.
    for (int k = 0; k < 600; k++) begin
      bus.start_i = ($urandom_range(0, 2) == 0);
      bus.abort_i = ($urandom_range(0, 15) == 0);
      bus.a_i     = 10'($urandom);
      bus.b_i     = pick_b();
      @(negedge clk); #1;
    end
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
